// File: rtl/a23_run_pkg.sv
// a23_run_pkg: shared definitions for the a23_gc_main run harness.
//   - run_state_t : harness FSM state encoding
//   - WORD_W      : width of one streamed memory word
//   - idx_w()     : width of an index counter that spans n entries
package a23_run_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } run_state_t;

  // Counters need at least one bit even for a single-entry memory.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/a23_run_unload.sv
// a23_run_unload: captures the core output bus into a snapshot and streams it
// out one 32-bit word at a time through a valid/ready port.
//
// Optional macro: A23_RUN_CHECKSUM_EN adds o_csum, a rotate-xor checksum of
// every accepted output word, cleared when the snapshot is taken.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_cap          take snapshot of i_o (one cycle, on RUN exit)
//   i_active       harness is in UNLOAD; drives o_valid
//   i_o            core output bus, OUT_MEM_SIZE words
//   i_ready        consumer ready
//   o_valid        output word valid
//   o_data         current snapshot word
//   o_last         current word is the final one
//   o_last_acc     final word accepted this cycle
//   o_csum         running checksum (only with A23_RUN_CHECKSUM_EN)
module a23_run_unload
  import a23_run_pkg::*;
#(
  parameter int OUT_MEM_SIZE = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cap,
  input  logic                           i_active,
  input  logic [OUT_MEM_SIZE*WORD_W-1:0] i_o,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [WORD_W-1:0]              o_data,
  output logic                           o_last,
  output logic                           o_last_acc
`ifdef A23_RUN_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]              o_csum
`endif
);

  localparam int JW = idx_w(OUT_MEM_SIZE);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_MEM_SIZE - 1);

  logic [OUT_MEM_SIZE*WORD_W-1:0] r_snap;
  logic [JW-1:0]                  r_j;
  logic                           w_acc;
  logic                           w_at_last;
  logic [JW+4:0]                  w_jbit;

  assign w_acc     = i_active && i_ready;
  assign w_at_last = (r_j == J_LAST);
  assign w_jbit    = {r_j, 5'd0};

  // Words come straight from the registered snapshot: zero latency, and the
  // word holds while the consumer stalls because r_j only moves on accept.
  assign o_valid    = i_active;
  assign o_data     = r_snap[w_jbit +: WORD_W];
  assign o_last     = i_active && w_at_last;
  assign o_last_acc = w_acc && w_at_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snap <= '0;
      r_j    <= '0;
    end else if (i_cap) begin
      r_snap <= i_o;
      r_j    <= '0;
    end else if (w_acc) begin
      r_j <= w_at_last ? '0 : r_j + 1'b1;
    end
  end

`ifdef A23_RUN_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= '0;
    end else if (i_cap) begin
      r_csum <= '0;
    end else if (w_acc) begin
      r_csum <= {r_csum[WORD_W-2:0], r_csum[WORD_W-1]} ^ o_data;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: rtl/a23_run_ctrl.sv
// a23_run_ctrl: synthesizable run harness for a23_gc_main.
// Loads code/G/E images from a word stream, holds the core in reset while
// loading, runs it while counting cycles until terminate (or the optional
// watchdog), then snapshots and streams out the core output bus.
//
// Optional macro: A23_RUN_CHECKSUM_EN adds out_csum (checksum of unloaded words).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse; begins a load from IDLE or DONE
//   in_valid/in_ready/in_data   load stream (code, then G, then E words)
//   core_rst            reset to the core (low only in RUN)
//   p_init/g_init/e_init        flat image buses, word i at [32*i +: 32]
//   o, terminate        core output bus and completion flag
//   out_valid/out_ready/out_data/out_last   unload stream
//   cc                  RUN cycles counted, saturating
//   busy, timeout, done status
module a23_run_ctrl
  import a23_run_pkg::*;
#(
  parameter int CODE_MEM_SIZE = 512,
  parameter int G_MEM_SIZE    = 64,
  parameter int E_MEM_SIZE    = 64,
  parameter int OUT_MEM_SIZE  = 64,
  parameter int CC_WIDTH      = 32,
  parameter int MAX_CC        = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_W-1:0]               in_data,
  output logic                            core_rst,
  output logic [CODE_MEM_SIZE*WORD_W-1:0] p_init,
  output logic [G_MEM_SIZE*WORD_W-1:0]    g_init,
  output logic [E_MEM_SIZE*WORD_W-1:0]    e_init,
  input  logic [OUT_MEM_SIZE*WORD_W-1:0]  o,
  input  logic                            terminate,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WORD_W-1:0]               out_data,
  output logic                            out_last,
  output logic [CC_WIDTH-1:0]             cc,
  output logic                            busy,
  output logic                            timeout,
  output logic                            done
`ifdef A23_RUN_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]               out_csum
`endif
);

  localparam int N_TOT = CODE_MEM_SIZE + G_MEM_SIZE + E_MEM_SIZE;
  localparam int IW    = idx_w(N_TOT);
  localparam int PW    = idx_w(CODE_MEM_SIZE);
  localparam int GW    = idx_w(G_MEM_SIZE);
  localparam int EW    = idx_w(E_MEM_SIZE);
  localparam logic [IW-1:0] CODE_END = IW'(CODE_MEM_SIZE);
  localparam logic [IW-1:0] G_END    = IW'(CODE_MEM_SIZE + G_MEM_SIZE);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_TOT - 1);
  localparam logic [CC_WIDTH-1:0] MAX_CC_L = CC_WIDTH'(MAX_CC);
  localparam bit WD_EN = (MAX_CC > 0);

  run_state_t r_state, w_next;

  logic [CODE_MEM_SIZE*WORD_W-1:0] r_p_init;
  logic [G_MEM_SIZE*WORD_W-1:0]    r_g_init;
  logic [E_MEM_SIZE*WORD_W-1:0]    r_e_init;
  logic [IW-1:0]                   r_idx;
  logic [CC_WIDTH-1:0]             r_cc;
  logic                            r_timeout;

  logic          w_load_go;
  logic          w_acc_in;
  logic          w_last_in;
  logic          w_in_run;
  logic          w_wd;
  logic          w_cap;
  logic          w_unl_active;
  logic          w_unl_done;
  logic [IW-1:0] w_goff;
  logic [IW-1:0] w_eoff;
  logic [PW+4:0] w_pbit;
  logic [GW+4:0] w_gbit;
  logic [EW+4:0] w_ebit;

  assign w_load_go    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_acc_in     = (r_state == ST_LOAD) && in_valid;
  assign w_last_in    = (r_idx == IDX_LAST);
  assign w_in_run     = (r_state == ST_RUN);
  assign w_wd         = WD_EN && (r_cc == MAX_CC_L);
  // Terminate has priority over the watchdog in the same cycle.
  assign w_cap        = w_in_run && (terminate || w_wd);
  assign w_unl_active = (r_state == ST_UNLOAD);

  // G and E slot indices are rebased to zero within their own buses.
  assign w_goff = r_idx - CODE_END;
  assign w_eoff = r_idx - G_END;
  assign w_pbit = {r_idx[PW-1:0], 5'd0};
  assign w_gbit = {w_goff[GW-1:0], 5'd0};
  assign w_ebit = {w_eoff[EW-1:0], 5'd0};

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // ---- FSM next state and control outputs ----
  always_comb begin
    w_next   = r_state;
    core_rst = 1'b1;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_go) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_acc_in && w_last_in) w_next = ST_RUN;
      end
      ST_RUN: begin
        core_rst = 1'b0;
        busy     = 1'b1;
        if (w_cap) w_next = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        busy = 1'b1;
        if (w_unl_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_load_go) w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---- Load demux: word k goes to code, G or E slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_init <= '0;
      r_g_init <= '0;
      r_e_init <= '0;
      r_idx    <= '0;
    end else if (w_load_go) begin
      r_idx <= '0;
    end else if (w_acc_in) begin
      if (r_idx < CODE_END)   r_p_init[w_pbit +: WORD_W] <= in_data;
      else if (r_idx < G_END) r_g_init[w_gbit +: WORD_W] <= in_data;
      else                    r_e_init[w_ebit +: WORD_W] <= in_data;
      r_idx <= w_last_in ? '0 : r_idx + 1'b1;
    end
  end

  // ---- Cycle counter and watchdog flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc      <= '0;
      r_timeout <= 1'b0;
    end else if (w_load_go) begin
      r_cc      <= '0;
      r_timeout <= 1'b0;
    end else if (w_in_run && !terminate) begin
      if (w_wd)              r_timeout <= 1'b1;
      else if (r_cc != '1)   r_cc      <= r_cc + 1'b1;
    end
  end

  a23_run_unload #(
    .OUT_MEM_SIZE(OUT_MEM_SIZE)
  ) u_unload (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cap      (w_cap),
    .i_active   (w_unl_active),
    .i_o        (o),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_last     (out_last),
    .o_last_acc (w_unl_done)
`ifdef A23_RUN_CHECKSUM_EN
    ,
    .o_csum     (out_csum)
`endif
  );

  assign p_init  = r_p_init;
  assign g_init  = r_g_init;
  assign e_init  = r_e_init;
  assign cc      = r_cc;
  assign timeout = r_timeout;

endmodule

// File: doc/a23_run_ctrl.md
Name: a23_run_ctrl

Overview:
- Synthesizable run harness for a23_gc_main with parametrised memory sizes.
- Streams code, G and E words in through a valid/ready port and drives the core's flat p_init/g_init/e_init buses.
- Holds the core in reset during load, releases it, and counts cycles until terminate; an optional watchdog can end the run early.
- Snapshots the core's output bus and streams it out word by word; on-chip replacement for file load/dump bench flows.

Parameters:
- CODE_MEM_SIZE, 512, code words; total p_init width is CODE_MEM_SIZE*32.
- G_MEM_SIZE, 64, garbler input words.
- E_MEM_SIZE, 64, evaluator input words.
- OUT_MEM_SIZE, 64, output words.
- CC_WIDTH, 32, width of the cycle counter.
- MAX_CC, 0, watchdog limit in run cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load.
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  32  input word
- core_rst  out  1  reset to a23_gc_main
- p_init  out  CODE_MEM_SIZE*32  code image
- g_init  out  G_MEM_SIZE*32  garbler image
- e_init  out  E_MEM_SIZE*32  evaluator image
- o  in  OUT_MEM_SIZE*32  core output bus
- terminate  in  1  core finished
- out_valid  out  1  output word valid
- out_ready  in  1  output consumer ready
- out_data  out  32  output word
- out_last  out  1  marks final output word
- cc  out  CC_WIDTH  cycles counted in RUN
- busy  out  1  state is not IDLE and not DONE
- timeout  out  1  the last run ended by watchdog
- done  out  1  state is DONE

Behaviour:
- Reset values: all outputs 0 except core_rst=1; init buses, snapshot and counters are cleared. Reset mid-operation aborts immediately to IDLE.
- States:
  - IDLE --start--> LOAD
  - LOAD --last word accepted--> RUN
  - RUN --terminate or watchdog--> UNLOAD
  - UNLOAD --last word accepted--> DONE
  - DONE --start--> LOAD
- start is ignored in LOAD, RUN and UNLOAD.
- Entering LOAD clears cc, timeout and the word index.
- LOAD:
  - in_ready=1 and core_rst=1.
  - Accepted word k (0..N-1, N=CODE+G+E) is written at 32-bit slot k; ordering is code, then G, then E.
  - Code slot i occupies p_init[32*(i+1)-1:32*i]; G and E slots use the same rule with index rebased to 0.
  - Init buses hold their value until the next LOAD overwrites them.
- RUN:
  - core_rst=0, in_ready=0.
  - cc increments every RUN cycle in which terminate=0. On the first cycle terminate=1, cc freezes, o is copied into the snapshot, and the state moves to UNLOAD.
  - If terminate is high on the first RUN cycle, cc=0.
  - Watchdog (MAX_CC>0): when cc==MAX_CC and terminate=0, set timeout=1, snapshot o, go to UNLOAD.
  - If terminate and the watchdog condition occur in the same cycle, terminate wins and timeout=0.
  - cc saturates at all-ones and does not wrap.
- UNLOAD:
  - core_rst=1; the snapshot decouples the output from the core.
  - out_data = snapshot word j (j=0..OUT_MEM_SIZE-1), out_valid=1; j advances on out_valid&&out_ready.
  - out_last=1 when j==OUT_MEM_SIZE-1.
  - out_data is stable while out_valid&&!out_ready.
- DONE: out_valid=0, core_rst=1; cc and timeout are held for readout.
- Index counters are sized with clog2 of the relevant count. Words go out zero-latency from the registered snapshot, with no bubbles when out_ready is held high.

Optional Feature:
- Macro A23_RUN_CHECKSUM_EN.
- With the macro defined: an extra output port out_csum[31:0] is added. It is cleared on entering UNLOAD and updated as out_csum <= rotl1(out_csum) ^ out_data on every accepted output word. It is valid in DONE.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package a23_run_pkg holds:
  - the state encoding (IDLE, LOAD, RUN, UNLOAD, DONE);
  - the word width constant 32;
  - a clog2-based index width function.
- One natural sub-module, a23_run_unload: snapshot register, output word mux, out handshake and the optional checksum.
- FSM, load demux and cycle counter stay in the top.

Test Plan:
- Load 640 words with value k+1 at index k, then terminate at cycle 37 -> p_init slot0=1, g_init slot0=513, e_init slot63=640; cc=37, timeout=0.
- Fill o with word j = 0xA5000000+j, terminate, then hold out_ready=1 -> 64 consecutive words 0xA5000000..0xA500003F; out_last only on the 64th; done=1 the following cycle.
- Toggle out_ready 1-0-1 per cycle -> no word is skipped or duplicated; out_data is held while stalled.
- MAX_CC=100 and terminate never asserts -> timeout=1 and cc=100; unload proceeds.
- Same setup with terminate asserted on the cycle where cc==100 -> timeout=0.
- Assert rst in the middle of LOAD (word 200), then start again -> core_rst=1, in_ready=1, and the reload starts from index 0.
- With A23_RUN_CHECKSUM_EN and all-zero o -> out_csum=0.
- With A23_RUN_CHECKSUM_EN and only word0=1 -> out_csum=0x80000000 (1 rotated 63 times).
